// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM responder: word-organised memory with byte-lane writes,
// full-word reads, a fixed number of wait states per OKAY transfer and the
// two-cycle ERROR response for illegal transfers.
//
// state    | meaning
// ---------+------------------------------------------------------------
// OK_IDLE  | no data phase pending, ready, OKAY
// WAIT_ST  | legal data phase stalled by the wait-state counter
// DATA_ST  | legal data phase completing this cycle (write commits here)
// ERR1     | first ERROR cycle, not ready
// ERR2     | second ERROR cycle, ready (may accept the next transfer)
module ahb_lite_sram_slave #(
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic [1:0]  HTRANS,
  input  logic        HMASTLOCK,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  localparam int          AW         = $clog2(MEM_DEPTH);
  localparam logic [32:0] ADDR_LIMIT = 33'(MEM_DEPTH) << 2;
  localparam logic [3:0]  WAIT_LOAD  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  localparam logic [2:0] OK_IDLE = 3'd0;
  localparam logic [2:0] WAIT_ST = 3'd1;
  localparam logic [2:0] DATA_ST = 3'd2;
  localparam logic [2:0] ERR1    = 3'd3;
  localparam logic [2:0] ERR2    = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          wr_q, wr_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [3:0]    lanes_q, lanes_d;
  logic [31:0]   hrdata_q;
  logic [31:0]   mem_q [MEM_DEPTH];

  logic          accept, illegal, bus_ready, commit;
  logic [AW-1:0] addr_idx, rd_idx;
  logic [3:0]    addr_lanes;
  logic          rd_fast, rd_enter, rd_load;
  logic [31:0]   rd_word;
  logic          unused_ok;

  // Burst type, protection and lock carry no meaning for a plain SRAM.
  assign unused_ok = ^{HBURST, HPROT, HMASTLOCK};

  assign bus_ready = (state_q == OK_IDLE) || (state_q == DATA_ST) || (state_q == ERR2);
  assign accept    = HSEL && HREADY && HTRANS[1];
  assign illegal   = ({1'b0, HADDR} >= ADDR_LIMIT) || (HSIZE > 3'd2) ||
                     ((HSIZE == 3'd1) && HADDR[0]) ||
                     ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));
  assign addr_idx  = HADDR[AW+1:2];
  assign commit    = (state_q == DATA_ST) && wr_q;

  // Byte-lane mask of the transfer in the address phase (little-endian).
  always_comb begin
    addr_lanes = 4'b0000;
    case (HSIZE)
      3'd0:    addr_lanes = 4'b0001 << HADDR[1:0];
      3'd1:    addr_lanes = HADDR[1] ? 4'b1100 : 4'b0011;
      3'd2:    addr_lanes = 4'b1111;
      default: addr_lanes = 4'b0000;
    endcase
  end

  // Transfer sequencing: accept only in ready states, count waits, run the two ERROR cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    idx_d   = idx_q;
    lanes_d = lanes_q;
    case (state_q)
      WAIT_ST: begin
        if (cnt_q == 4'd0) state_d = DATA_ST;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ERR1: state_d = ERR2;
      default: begin
        if (accept && illegal) begin
          state_d = ERR1;
          wr_d    = 1'b0;
        end else if (accept) begin
          state_d = (WAIT_STATES > 0) ? WAIT_ST : DATA_ST;
          cnt_d   = WAIT_LOAD;
          wr_d    = HWRITE;
          idx_d   = addr_idx;
          lanes_d = addr_lanes;
        end else begin
          state_d = OK_IDLE;
          wr_d    = 1'b0;
        end
      end
    endcase
  end

  // Read data source, merging a write committing to the same word at the same edge.
  assign rd_fast  = (WAIT_STATES == 0) && bus_ready && accept && !illegal && !HWRITE;
  assign rd_enter = (state_q == WAIT_ST) && (cnt_q == 4'd0) && !wr_q;
  assign rd_load  = rd_fast || rd_enter;
  assign rd_idx   = rd_fast ? addr_idx : idx_q;

  always_comb begin
    rd_word = mem_q[rd_idx];
    for (int i = 0; i < 4; i++) begin
      if (commit && (idx_q == rd_idx) && lanes_q[i]) rd_word[8*i +: 8] = HWDATA[8*i +: 8];
    end
  end

  // Control and read-data registers; reset abandons any pending data phase.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q  <= OK_IDLE;
      cnt_q    <= 4'd0;
      wr_q     <= 1'b0;
      idx_q    <= '0;
      lanes_q  <= 4'b0000;
      hrdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      lanes_q <= lanes_d;
      if (rd_load) hrdata_q <= rd_word;
    end
  end

  // SRAM array: contents survive reset; only enabled lanes of a completing write change.
  always_ff @(posedge HCLK) begin
    if (!HRESET && commit) begin
      for (int i = 0; i < 4; i++) begin
        if (lanes_q[i]) mem_q[idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
      end
    end
  end

  assign HREADYOUT = !((state_q == WAIT_ST) || (state_q == ERR1));
  assign HRESP     = (state_q == ERR1) || (state_q == ERR2);
  assign HRDATA    = hrdata_q;

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Directed bench: u0 has no wait states, u2 has two; both share the bus
// signals and the reset but have their own select and ready loop-back.
module tb_ahb_lite_sram_slave;

  logic        hclk = 1'b0;
  logic        hreset = 1'b1;
  logic        hsel0 = 1'b0, hsel2 = 1'b0;
  logic [31:0] haddr = 32'd0;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'd2;
  logic [1:0]  htrans = 2'b00;
  logic [31:0] hwdata = 32'd0;
  logic        hready0, hresp0, hready2, hresp2;
  logic [31:0] hrdata0, hrdata2;

  int total = 0;
  int bad   = 0;

  always #5 hclk = ~hclk;

  ahb_lite_sram_slave #(.MEM_DEPTH(256), .WAIT_STATES(0)) u0 (
    .HCLK(hclk), .HRESET(hreset), .HSEL(hsel0), .HADDR(haddr), .HWRITE(hwrite),
    .HSIZE(hsize), .HBURST(3'b001), .HPROT(4'b0011), .HTRANS(htrans), .HMASTLOCK(1'b0),
    .HREADY(hready0), .HWDATA(hwdata), .HREADYOUT(hready0), .HRESP(hresp0), .HRDATA(hrdata0)
  );

  ahb_lite_sram_slave #(.MEM_DEPTH(256), .WAIT_STATES(2)) u2 (
    .HCLK(hclk), .HRESET(hreset), .HSEL(hsel2), .HADDR(haddr), .HWRITE(hwrite),
    .HSIZE(hsize), .HBURST(3'b001), .HPROT(4'b0011), .HTRANS(htrans), .HMASTLOCK(1'b0),
    .HREADY(hready2), .HWDATA(hwdata), .HREADYOUT(hready2), .HRESP(hresp2), .HRDATA(hrdata2)
  );

  task automatic bus_idle();
    hsel0 = 1'b0; hsel2 = 1'b0; htrans = 2'b00; hwrite = 1'b0;
  endtask

  task automatic addr_ph(input bit d2, input logic [31:0] a, input bit w, input logic [2:0] s);
    hsel0 = !d2; hsel2 = d2; haddr = a; hwrite = w; hsize = s; htrans = 2'b10;
  endtask

  task automatic wr0(input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
    addr_ph(1'b0, a, 1'b1, s);
    @(negedge hclk); hwdata = d; bus_idle();
    @(negedge hclk);
  endtask

  task automatic rd0(input logic [31:0] a);
    addr_ph(1'b0, a, 1'b0, 3'd2);
    @(negedge hclk); bus_idle();
  endtask

  task automatic rd2(input logic [31:0] a, output int waits, output logic [31:0] data);
    addr_ph(1'b1, a, 1'b0, 3'd2);
    @(negedge hclk); bus_idle();
    waits = 0;
    while (hready2 !== 1'b1 && waits < 10) begin
      waits++;
      @(negedge hclk);
    end
    data = hrdata2;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge hclk);
    hreset = 1'b0;
    wr0(32'h4, 3'd2, 32'h1234_5678);
    rd0(32'h4);
    total++; if (hrdata0 !== 32'h1234_5678) begin bad++; $display("FAIL preload_read: got %h want %h", hrdata0, 32'h1234_5678); end
    hreset = 1'b1;
    repeat (2) @(negedge hclk);
    total++; if (hready0 !== 1'b1) begin bad++; $display("FAIL rst_ready0: got %b want 1", hready0); end
    total++; if (hresp0 !== 1'b0) begin bad++; $display("FAIL rst_resp0: got %b want 0", hresp0); end
    total++; if (hrdata0 !== 32'd0) begin bad++; $display("FAIL rst_rdata0: got %h want 0", hrdata0); end
    total++; if (hready2 !== 1'b1 || hresp2 !== 1'b0 || hrdata2 !== 32'd0) begin
      bad++; $display("FAIL rst_u2: got ready=%b resp=%b rdata=%h want 1 0 0", hready2, hresp2, hrdata2);
    end
    hreset = 1'b0;
    rd0(32'h4);
    total++; if (hrdata0 !== 32'h1234_5678) begin bad++; $display("FAIL mem_retained: got %h want %h", hrdata0, 32'h1234_5678); end
  endtask

  task automatic test_forward();
    addr_ph(1'b0, 32'h4, 1'b1, 3'd2);
    @(negedge hclk);
    total++; if (hready0 !== 1'b1) begin bad++; $display("FAIL fwd_wr_ready: got %b want 1", hready0); end
    hwdata = 32'hAABB_CCDD;
    addr_ph(1'b0, 32'h4, 1'b0, 3'd2);
    @(negedge hclk);
    total++; if (hrdata0 !== 32'hAABB_CCDD) begin bad++; $display("FAIL fwd_rdata: got %h want %h", hrdata0, 32'hAABB_CCDD); end
    total++; if (hready0 !== 1'b1 || hresp0 !== 1'b0) begin bad++; $display("FAIL fwd_resp: got ready=%b resp=%b want 1 0", hready0, hresp0); end
    bus_idle();
    @(negedge hclk);
    total++; if (hrdata0 !== 32'hAABB_CCDD) begin bad++; $display("FAIL fwd_hold: got %h want %h", hrdata0, 32'hAABB_CCDD); end
  endtask

  task automatic test_lanes();
    wr0(32'h8, 3'd2, 32'h0000_0000);
    wr0(32'h9, 3'd0, 32'h0000_EF00);
    wr0(32'hA, 3'd1, 32'hABCD_0000);
    rd0(32'h8);
    total++; if (hrdata0 !== 32'hABCD_EF00) begin bad++; $display("FAIL lanes_half_byte: got %h want %h", hrdata0, 32'hABCD_EF00); end
    wr0(32'hB, 3'd0, 32'h7700_0000);
    rd0(32'h8);
    total++; if (hrdata0 !== 32'h77CD_EF00) begin bad++; $display("FAIL lanes_top_byte: got %h want %h", hrdata0, 32'h77CD_EF00); end
  endtask

  task automatic test_back_to_back();
    addr_ph(1'b0, 32'h10, 1'b1, 3'd2);
    @(negedge hclk); hwdata = 32'h1111_1111; addr_ph(1'b0, 32'h14, 1'b1, 3'd2);
    @(negedge hclk); hwdata = 32'h2222_2222; addr_ph(1'b0, 32'h10, 1'b0, 3'd2);
    total++; if (hready0 !== 1'b1) begin bad++; $display("FAIL b2b_ready: got %b want 1", hready0); end
    @(negedge hclk); hwdata = 32'h0; addr_ph(1'b0, 32'h14, 1'b0, 3'd2);
    total++; if (hrdata0 !== 32'h1111_1111) begin bad++; $display("FAIL b2b_rd0: got %h want %h", hrdata0, 32'h1111_1111); end
    @(negedge hclk); bus_idle();
    total++; if (hrdata0 !== 32'h2222_2222) begin bad++; $display("FAIL b2b_rd1: got %h want %h", hrdata0, 32'h2222_2222); end
  endtask

  task automatic test_waits();
    int          waits;
    logic [31:0] data;
    addr_ph(1'b1, 32'h4, 1'b1, 3'd2);
    @(negedge hclk); bus_idle(); hwdata = 32'hDEAD_BEEF;
    total++; if (hready2 !== 1'b0) begin bad++; $display("FAIL ws_wr_wait1: got %b want 0", hready2); end
    @(negedge hclk); hwdata = 32'h0BAD_0BAD;
    total++; if (hready2 !== 1'b0) begin bad++; $display("FAIL ws_wr_wait2: got %b want 0", hready2); end
    @(negedge hclk); hwdata = 32'hAABB_CCDD;
    total++; if (hready2 !== 1'b1) begin bad++; $display("FAIL ws_wr_data: got %b want 1", hready2); end
    @(negedge hclk);
    addr_ph(1'b1, 32'h4, 1'b0, 3'd2);
    @(negedge hclk); bus_idle();
    total++; if (hrdata2 !== 32'd0) begin bad++; $display("FAIL ws_rd_early: got %h want 0", hrdata2); end
    waits = 0;
    while (hready2 !== 1'b1 && waits < 10) begin
      waits++;
      @(negedge hclk);
    end
    data = hrdata2;
    total++; if (waits !== 2) begin bad++; $display("FAIL ws_rd_waits: got %0d want 2", waits); end
    total++; if (data !== 32'hAABB_CCDD) begin bad++; $display("FAIL ws_rd_data: got %h want %h", data, 32'hAABB_CCDD); end
    total++; if (hresp2 !== 1'b0) begin bad++; $display("FAIL ws_rd_resp: got %b want 0", hresp2); end
  endtask

  task automatic test_errors();
    wr0(32'h0, 3'd2, 32'h0000_0A0A);
    rd0(32'h14);
    addr_ph(1'b0, 32'h2, 1'b0, 3'd2);
    @(negedge hclk); bus_idle();
    total++; if (hready0 !== 1'b0 || hresp0 !== 1'b1) begin bad++; $display("FAIL err_rd_c1: got ready=%b resp=%b want 0 1", hready0, hresp0); end
    @(negedge hclk);
    total++; if (hready0 !== 1'b1 || hresp0 !== 1'b1) begin bad++; $display("FAIL err_rd_c2: got ready=%b resp=%b want 1 1", hready0, hresp0); end
    total++; if (hrdata0 !== 32'h2222_2222) begin bad++; $display("FAIL err_rdata_held: got %h want %h", hrdata0, 32'h2222_2222); end
    addr_ph(1'b0, 32'h400, 1'b1, 3'd2);
    @(negedge hclk); hwdata = 32'hFFFF_FFFF; addr_ph(1'b0, 32'h9, 1'b1, 3'd1);
    total++; if (hready0 !== 1'b0 || hresp0 !== 1'b1) begin bad++; $display("FAIL err_wr_c1: got ready=%b resp=%b want 0 1", hready0, hresp0); end
    @(negedge hclk);
    total++; if (hready0 !== 1'b1 || hresp0 !== 1'b1) begin bad++; $display("FAIL err_wr_c2: got ready=%b resp=%b want 1 1", hready0, hresp0); end
    @(negedge hclk); hwdata = 32'h0; addr_ph(1'b0, 32'h4, 1'b0, 3'd2);
    total++; if (hready0 !== 1'b0 || hresp0 !== 1'b1) begin bad++; $display("FAIL err_half_c1: got ready=%b resp=%b want 0 1", hready0, hresp0); end
    @(negedge hclk);
    total++; if (hready0 !== 1'b1 || hresp0 !== 1'b1) begin bad++; $display("FAIL err_half_c2: got ready=%b resp=%b want 1 1", hready0, hresp0); end
    @(negedge hclk); bus_idle();
    total++; if (hready0 !== 1'b1 || hresp0 !== 1'b0 || hrdata0 !== 32'hAABB_CCDD) begin
      bad++; $display("FAIL err_then_ok: got ready=%b resp=%b rdata=%h want 1 0 aabbccdd", hready0, hresp0, hrdata0);
    end
    rd0(32'h8);
    total++; if (hrdata0 !== 32'h77CD_EF00) begin bad++; $display("FAIL err_no_write8: got %h want %h", hrdata0, 32'h77CD_EF00); end
    rd0(32'h0);
    total++; if (hrdata0 !== 32'h0000_0A0A) begin bad++; $display("FAIL err_no_wrap: got %h want %h", hrdata0, 32'h0000_0A0A); end
  endtask

  task automatic test_idle_busy();
    wr0(32'h28, 3'd2, 32'h2828_2828);
    wr0(32'h2C, 3'd2, 32'h2C2C_2C2C);
    rd0(32'h28);
    addr_ph(1'b0, 32'h20, 1'b1, 3'd2);
    @(negedge hclk); hwdata = 32'h5555_0001; hsel0 = 1'b1; htrans = 2'b01; haddr = 32'h28; hwrite = 1'b1;
    @(negedge hclk); hwdata = 32'hEEEE_EEEE; hsel0 = 1'b0; htrans = 2'b11; haddr = 32'h2C;
    total++; if (hready0 !== 1'b1 || hresp0 !== 1'b0) begin bad++; $display("FAIL busy_okay: got ready=%b resp=%b want 1 0", hready0, hresp0); end
    total++; if (hrdata0 !== 32'h2828_2828) begin bad++; $display("FAIL busy_hold: got %h want %h", hrdata0, 32'h2828_2828); end
    @(negedge hclk); hsel0 = 1'b1; htrans = 2'b00; haddr = 32'h28;
    total++; if (hready0 !== 1'b1 || hresp0 !== 1'b0) begin bad++; $display("FAIL nosel_okay: got ready=%b resp=%b want 1 0", hready0, hresp0); end
    @(negedge hclk); htrans = 2'b11; haddr = 32'h24;
    total++; if (hready0 !== 1'b1 || hrdata0 !== 32'h2828_2828) begin bad++; $display("FAIL idle_hold: got ready=%b rdata=%h want 1 28282828", hready0, hrdata0); end
    @(negedge hclk); hwdata = 32'h5555_0002; bus_idle();
    @(negedge hclk);
    rd0(32'h20);
    total++; if (hrdata0 !== 32'h5555_0001) begin bad++; $display("FAIL burst_beat0: got %h want %h", hrdata0, 32'h5555_0001); end
    rd0(32'h24);
    total++; if (hrdata0 !== 32'h5555_0002) begin bad++; $display("FAIL burst_beat1: got %h want %h", hrdata0, 32'h5555_0002); end
    rd0(32'h28);
    total++; if (hrdata0 !== 32'h2828_2828) begin bad++; $display("FAIL busy_no_write: got %h want %h", hrdata0, 32'h2828_2828); end
    rd0(32'h2C);
    total++; if (hrdata0 !== 32'h2C2C_2C2C) begin bad++; $display("FAIL nosel_no_write: got %h want %h", hrdata0, 32'h2C2C_2C2C); end
  endtask

  task automatic test_reset_in_wait();
    int          waits;
    logic [31:0] data;
    addr_ph(1'b1, 32'h4, 1'b1, 3'd2);
    @(negedge hclk); hwdata = 32'h9999_9999; bus_idle(); hreset = 1'b1;
    total++; if (hready2 !== 1'b0) begin bad++; $display("FAIL rw_in_wait: got %b want 0", hready2); end
    @(negedge hclk); hreset = 1'b0;
    total++; if (hready2 !== 1'b1 || hresp2 !== 1'b0 || hrdata2 !== 32'd0) begin
      bad++; $display("FAIL rw_outputs: got ready=%b resp=%b rdata=%h want 1 0 0", hready2, hresp2, hrdata2);
    end
    repeat (3) @(negedge hclk);
    rd2(32'h4, waits, data);
    total++; if (waits !== 2) begin bad++; $display("FAIL rw_rd_waits: got %0d want 2", waits); end
    total++; if (data !== 32'hAABB_CCDD) begin bad++; $display("FAIL rw_unchanged: got %h want %h", data, 32'hAABB_CCDD); end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_lanes();
    test_back_to_back();
    test_waits();
    test_errors();
    test_idle_busy();
    test_reset_in_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
